aes_key_sched_ctrl: RTL and testbench

//  Iterative AES-128 key-schedule controller. Accepts a cipher key over a valid/ready handshake.

---
 rtl/aes_key_sched_ctrl_pkg.sv | 63 ++++++
 rtl/aes_key_sched_ctrl_expand_step.sv | 33 +++
 rtl/aes_key_sched_ctrl.sv | 120 ++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aes_key_sched_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_key_sched_ctrl_pkg                                          |
// | Purpose  : Shared AES-128 key-schedule constants and helpers: round count,|
// |            round-constant table, S-box, RotWord/SubWord functions, block |
// |            type and controller state encoding.                            |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package aes_key_sched_ctrl_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_READY  = 2'd2
    } ks_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Round constant for a 1-based round number; 0 outside the table.
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (rnd == 4'(i)) v = RCON[i];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_sched_ctrl_expand_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_key_sched_ctrl_expand_step                                  |
// | Purpose  : One combinational AES-128 key-expansion step.                  |
// | Ports    : i_prev_key [127:0] previous round key {w0,w1,w2,w3}            |
// |            i_rcon     [7:0]   round constant for the key being produced  |
// |            o_next_key [127:0] next round key {n0,n1,n2,n3}               |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module aes_key_sched_ctrl_expand_step
    import aes_key_sched_ctrl_pkg::*;
(
    input  logic [127:0] i_prev_key,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_next_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = i_prev_key;

    assign w_t  = sub_word(rot_word(w_w3)) ^ {i_rcon, 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_n0 ^ w_w1;
    assign w_n2 = w_n1 ^ w_w2;
    assign w_n3 = w_n2 ^ w_w3;

    assign o_next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_key_sched_ctrl                                              |
// | Purpose  : Iterative AES-128 key-schedule controller. Takes a cipher key  |
// |            over valid/ready, expands one round key per clock into an     |
// |            11-entry register file and serves it through a registered     |
// |            read port.                                                     |
// | Ports    : clk, rst_n (async, active low)                                 |
// |            key_valid/key_ready/key_in  - key handshake                   |
// |            zeroize                     - sync abort (+clear if ZEROIZE)  |
// |            busy, keys_valid            - status                          |
// |            rd_idx -> rd_key            - 1-cycle-latency key read        |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int NR      = 10,
    parameter int KEY_W   = 128,
    parameter int ZEROIZE = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    input  logic             zeroize,
    output logic             busy,
    output logic             keys_valid,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);

    generate
        if (NR != AES_NR || KEY_W != 128) begin : g_bad_params
            $error("aes_key_sched_ctrl: only NR=10 and KEY_W=128 are supported");
        end
    endgenerate

    localparam logic [1:0] c_ST_IDLE   = KS_IDLE;
    localparam logic [1:0] c_ST_EXPAND = KS_EXPAND;
    localparam logic [1:0] c_ST_READY  = KS_READY;
    localparam logic [3:0] c_NR_IDX    = 4'(NR);

    logic [1:0]       r_state;
    logic [3:0]       r_rnd;
    logic [KEY_W-1:0] r_slot [0:NR];
    logic [KEY_W-1:0] r_rd_key;

    logic [3:0]       w_prev_idx;
    logic [7:0]       w_rcon;
    logic [KEY_W-1:0] w_next_key;
    logic             w_accept;

    // Status is a pure decode of the state register, so all three flags
    // change on exactly the same edge as the state.
    assign key_ready  = (r_state != c_ST_EXPAND);
    assign busy       = (r_state == c_ST_EXPAND);
    assign keys_valid = (r_state == c_ST_READY);
    assign rd_key     = r_rd_key;

    assign w_accept   = key_valid && key_ready && !zeroize;

    // r_rnd is 1..NR while expanding; clamp keeps the index in range otherwise.
    assign w_prev_idx = (r_rnd == 4'd0) ? 4'd0 : r_rnd - 4'd1;
    assign w_rcon     = rcon_of(r_rnd);

    aes_key_sched_ctrl_expand_step u_step (
        .i_prev_key (r_slot[w_prev_idx]),
        .i_rcon     (w_rcon),
        .o_next_key (w_next_key)
    );

    // Control path: state and round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_rnd   <= 4'd0;
        end else if (zeroize) begin
            r_state <= c_ST_IDLE;
            r_rnd   <= 4'd0;
        end else if (w_accept) begin
            r_state <= c_ST_EXPAND;
            r_rnd   <= 4'd1;
        end else if (r_state == c_ST_EXPAND) begin
            if (r_rnd == c_NR_IDX) begin
                r_state <= c_ST_READY;
            end else begin
                r_rnd <= r_rnd + 4'd1;
            end
        end
    end

    // Round-key file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) r_slot[i] <= '0;
        end else if (zeroize) begin
            if (ZEROIZE != 0) begin
                for (int i = 0; i <= NR; i++) r_slot[i] <= '0;
            end
        end else if (w_accept) begin
            r_slot[0] <= key_in;
        end else if (r_state == c_ST_EXPAND) begin
            r_slot[r_rnd] <= w_next_key;
        end
    end

    // Registered read port; no write bypass, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_key <= '0;
        end else begin
            r_rd_key <= (rd_idx <= c_NR_IDX) ? r_slot[rd_idx] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_key_sched_ctrl                                           |
// | Purpose  : Directed self-checking bench for aes_key_sched_ctrl using      |
// |            FIPS-197 and all-zero key schedules.                           |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] c_KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_KEY_ZERO  = 128'h0;
    localparam logic [127:0] c_ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] c_KEY_B     = 128'hffeeddccbbaa99887766554433221100;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         zeroize;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_tests;
    int n_fail;

    aes_key_sched_ctrl #(
        .NR      (10),
        .KEY_W   (128),
        .ZEROIZE (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .zeroize    (zeroize),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present idx, then sample the registered data one cycle later.
    task automatic read_chk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        @(negedge clk);
        rd_idx = idx;
        @(negedge clk);
        chk(tag, rd_key, exp);
    endtask

    // Present key for one edge; returns at the negedge after the accept edge T0.
    task automatic present_key(input logic [127:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_in    = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = '0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        zeroize   = 1'b0;
        rd_idx    = 4'd0;
        cycles(3);
        rst_n = 1'b1;

        // Reset state.
        chk("rst_key_ready",  {127'h0, key_ready},  128'h1);
        chk("rst_busy",       {127'h0, busy},       128'h0);
        chk("rst_keys_valid", {127'h0, keys_valid}, 128'h0);
        chk("rst_rd_key",     rd_key,               128'h0);

        // FIPS-197 key, with latency checks after T0, T9 and T10.
        present_key(c_KEY_FIPS);
        chk("fips_t0_busy",       {127'h0, busy},       128'h1);
        chk("fips_t0_key_ready",  {127'h0, key_ready},  128'h0);
        cycles(9);
        chk("fips_t9_busy",       {127'h0, busy},       128'h1);
        chk("fips_t9_keys_valid", {127'h0, keys_valid}, 128'h0);
        cycles(1);
        chk("fips_t10_busy",       {127'h0, busy},       128'h0);
        chk("fips_t10_keys_valid", {127'h0, keys_valid}, 128'h1);
        chk("fips_t10_key_ready",  {127'h0, key_ready},  128'h1);
        read_chk("fips_slot0",  4'd0,  c_KEY_FIPS);
        read_chk("fips_slot1",  4'd1,  c_FIPS_R1);
        read_chk("fips_slot10", 4'd10, c_FIPS_R10);

        // Out-of-range indices read zero even with a populated file.
        read_chk("rd_idx11", 4'd11, 128'h0);
        read_chk("rd_idx15", 4'd15, 128'h0);

        // New key accepted in READY.
        present_key(c_KEY_ZERO);
        chk("reload_t0_keys_valid", {127'h0, keys_valid}, 128'h0);
        chk("reload_t0_busy",       {127'h0, busy},       128'h1);
        cycles(9);
        chk("reload_t9_keys_valid", {127'h0, keys_valid}, 128'h0);
        cycles(1);
        chk("reload_t10_keys_valid", {127'h0, keys_valid}, 128'h1);
        read_chk("zero_slot1",  4'd1,  c_ZERO_R1);
        read_chk("zero_slot10", 4'd10, c_ZERO_R10);

        // Key B pulsed at T4 of A's expansion must be ignored.
        present_key(c_KEY_FIPS);
        cycles(3);
        key_valid = 1'b1;
        key_in    = c_KEY_B;
        chk("ign_t4_key_ready", {127'h0, key_ready}, 128'h0);
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = '0;
        cycles(6);
        chk("ign_t10_keys_valid", {127'h0, keys_valid}, 128'h1);
        read_chk("ign_slot0",  4'd0,  c_KEY_FIPS);
        read_chk("ign_slot1",  4'd1,  c_FIPS_R1);
        read_chk("ign_slot10", 4'd10, c_FIPS_R10);

        // zeroize at T5 together with key_valid.
        present_key(c_KEY_ZERO);
        cycles(4);
        zeroize   = 1'b1;
        key_valid = 1'b1;
        key_in    = c_KEY_FIPS;
        @(negedge clk);
        zeroize   = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        chk("zer_busy",       {127'h0, busy},       128'h0);
        chk("zer_keys_valid", {127'h0, keys_valid}, 128'h0);
        chk("zer_key_ready",  {127'h0, key_ready},  128'h1);
        cycles(2);
        chk("zer_not_accepted", {127'h0, busy}, 128'h0);
        read_chk("zer_slot0",  4'd0,  128'h0);
        read_chk("zer_slot1",  4'd1,  128'h0);
        read_chk("zer_slot5",  4'd5,  128'h0);
        read_chk("zer_slot10", 4'd10, 128'h0);

        // Asynchronous reset at T3 of an expansion.
        rd_idx = 4'd0;
        present_key(c_KEY_FIPS);
        cycles(2);
        chk("pre_rst_rd_key", rd_key, c_KEY_FIPS);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",       {127'h0, busy},       128'h0);
        chk("arst_keys_valid", {127'h0, keys_valid}, 128'h0);
        chk("arst_key_ready",  {127'h0, key_ready},  128'h1);
        chk("arst_rd_key",     rd_key,               128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        read_chk("arst_slot0", 4'd0, 128'h0);
        read_chk("arst_slot1", 4'd1, 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
